vga_scan_generator: RTL and testbench

Raster timing generator and pixel output stage for the 800x480 VGA display. Produces the scan coordinates `vga_h`/`vga_v` consumed by the frame buffer, and takes back the frame buffer's `pixel_in` a fixed number of cycles later. It aligns that pixel with delayed sync/blank signals and drives the physical VGA pins (RGB, hsync, vsync, data-enable). Hack pixels are mapped to colours, and the 800x480 area outside the 512x256 Hack screen is painted with a border colour.

---
 rtl/vga_scan_if.sv | 24 ++
 rtl/vga_scan_generator.sv | 128 ++++++++++++
 tb/tb_vga_scan_generator.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// Scan-side bundle of the VGA generator: coordinates out to the frame buffer, pixel back,
// and the physical VGA pins.
interface vga_scan_if;
  logic [10:0] vga_h;
  logic [10:0] vga_v;
  logic        pixel_in;
  logic        new_frame;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    output vga_h, vga_v, new_frame, vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
    input  pixel_in
  );

  modport slave (
    input  vga_h, vga_v, new_frame, vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b,
    output pixel_in
  );
endinterface

// File: rtl/vga_scan_generator.sv
// Raster counters plus a delay-matched pixel output stage for an 800x480 VGA panel showing
// the 512x256 Hack screen inside a border.
module vga_scan_generator #(
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned H_FRONT      = 40,
  parameter int unsigned H_SYNC       = 128,
  parameter int unsigned H_BACK       = 88,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 13,
  parameter int unsigned V_SYNC       = 3,
  parameter int unsigned V_BACK       = 32,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0,
  parameter int unsigned PIPE_DELAY   = 1,
  parameter int unsigned SCREEN_W     = 512,
  parameter int unsigned SCREEN_H     = 256,
  parameter logic [23:0] ON_COLOR     = 24'h000000,
  parameter logic [23:0] OFF_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input logic        clk,
  input logic        reset,
  vga_scan_if.master vga
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef struct packed {
    logic active;
    logic in_screen;
    logic hs;
    logic vs;
  } scan_t;

  logic [10:0] h_q, v_q;
  logic        h_last, v_last;

  assign h_last = (h_q == 11'(H_TOTAL - 1));
  assign v_last = (v_q == 11'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_last ? 11'd0 : h_q + 11'd1;
      if (h_last) begin
        v_q <= v_last ? 11'd0 : v_q + 11'd1;
      end
    end
  end

  scan_t raw, dly;

  always_comb begin
    raw           = '0;
    raw.active    = (h_q < 11'(H_VISIBLE)) && (v_q < 11'(V_VISIBLE));
    raw.in_screen = (h_q < 11'(SCREEN_W)) && (v_q < 11'(SCREEN_H));
    raw.hs        = (h_q >= 11'(HS_START)) && (h_q < 11'(HS_END));
    raw.vs        = (v_q >= 11'(VS_START)) && (v_q < 11'(VS_END));
  end

  // Delay line matches the frame-buffer read latency (0..4) so control lines up with pixel_in.
  if (PIPE_DELAY == 0) begin : g_bypass
    assign dly = raw;
  end else begin : g_pipe
    scan_t pipe_q [PIPE_DELAY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dly = pipe_q[PIPE_DELAY-1];
  end

  logic        hsync_q, vsync_q, de_q;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = 24'h000000;
    if (dly.active) begin
      if (!dly.in_screen) begin
        rgb_d = BORDER_COLOR;
      end else begin
        rgb_d = vga.pixel_in ? ON_COLOR : OFF_COLOR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= dly.vs ? VSYNC_POL : ~VSYNC_POL;
      de_q    <= dly.active;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.vga_h     = h_q;
  assign vga.vga_v     = v_q;
  assign vga.new_frame = (h_q == 11'd0) && (v_q == 11'd0) && !reset;
  assign vga.vga_hsync = hsync_q;
  assign vga.vga_vsync = vsync_q;
  assign vga.vga_de    = de_q;
  assign vga.vga_r     = rgb_q[23:16];
  assign vga.vga_g     = rgb_q[15:8];
  assign vga.vga_b     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_generator.sv
// Directed bench: three shrunken-timing instances (delays 1, 3, 0 / inverted sync) plus one
// default-timing instance, all sharing clock and reset.
module tb_vga_scan_generator;

  // Small raster: H 20+2+3+3 = 28, V 10+1+2+2 = 15, screen 8x4, frame 420 clocks.
  localparam int SHT = 28;
  localparam int SVT = 15;
  localparam logic [23:0] SB = 24'h00FF00;

  logic clk;
  logic reset;
  int   total, bad, k;

  vga_scan_if if_a ();
  vga_scan_if if_b ();
  vga_scan_if if_c ();
  vga_scan_if if_d ();

  vga_scan_generator #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_DELAY(1), .SCREEN_W(8), .SCREEN_H(4), .BORDER_COLOR(SB)
  ) u_a (.clk(clk), .reset(reset), .vga(if_a));

  vga_scan_generator #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_DELAY(3), .SCREEN_W(8), .SCREEN_H(4), .BORDER_COLOR(SB)
  ) u_b (.clk(clk), .reset(reset), .vga(if_b));

  vga_scan_generator #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .PIPE_DELAY(0), .SCREEN_W(8), .SCREEN_H(4), .BORDER_COLOR(SB)
  ) u_c (.clk(clk), .reset(reset), .vga(if_c));

  vga_scan_generator u_d (.clk(clk), .reset(reset), .vga(if_d));

  // Frame-buffer models: checkerboard for a/c/d, a single lit pixel at (5,0) for b.
  logic       pix_a_q, pix_d_q;
  logic [2:0] pix_b_q;

  always @(posedge clk) begin
    pix_a_q <= if_a.vga_h[0] ^ if_a.vga_v[0];
    pix_d_q <= if_d.vga_h[0] ^ if_d.vga_v[0];
    pix_b_q <= {pix_b_q[1:0], (if_b.vga_h == 11'd5) && (if_b.vga_v == 11'd0)};
  end

  assign if_a.pixel_in = pix_a_q;
  assign if_b.pixel_in = pix_b_q[2];
  assign if_c.pixel_in = if_c.vga_h[0] ^ if_c.vga_v[0];
  assign if_d.pixel_in = pix_d_q;

  always #5 clk = ~clk;

  // Expected {hsync, vsync, de, rgb} at output cycle k for a small instance of delay d.
  function automatic logic [26:0] exp_small(int kk, int d, bit pol, bit single);
    int s;
    int h, v;
    logic a, scr, hs, vs, p;
    logic [23:0] rgb;
    s = kk - d - 1;
    if (s < 0) return {~pol, ~pol, 1'b0, 24'h000000};
    h   = s % SHT;
    v   = (s / SHT) % SVT;
    a   = (h < 20) && (v < 10);
    scr = (h < 8) && (v < 4);
    hs  = (h >= 22) && (h < 25);
    vs  = (v >= 11) && (v < 13);
    p   = single ? ((h == 5) && (v == 0)) : (((h + v) % 2) == 1);
    rgb = !a ? 24'h000000 : (!scr ? SB : (p ? 24'h000000 : 24'hFFFFFF));
    return {hs ? pol : ~pol, vs ? pol : ~pol, a, rgb};
  endfunction

  function automatic logic [26:0] pins_a();
    return {if_a.vga_hsync, if_a.vga_vsync, if_a.vga_de, if_a.vga_r, if_a.vga_g, if_a.vga_b};
  endfunction

  function automatic logic [26:0] pins_b();
    return {if_b.vga_hsync, if_b.vga_vsync, if_b.vga_de, if_b.vga_r, if_b.vga_g, if_b.vga_b};
  endfunction

  function automatic logic [26:0] pins_c();
    return {if_c.vga_hsync, if_c.vga_vsync, if_c.vga_de, if_c.vga_r, if_c.vga_g, if_c.vga_b};
  endfunction

  function automatic logic [26:0] pins_d();
    return {if_d.vga_hsync, if_d.vga_vsync, if_d.vga_de, if_d.vga_r, if_d.vga_g, if_d.vga_b};
  endfunction

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    k = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (60) tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({if_a.vga_h, if_a.vga_v} !== 22'd0) begin
      bad++;
      $display("FAIL reset_counters got h=%0d v=%0d want 0 0", if_a.vga_h, if_a.vga_v);
    end
    total++;
    if (if_a.new_frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_new_frame got=%b want=0", if_a.new_frame);
    end
    total++;
    if (pins_a() !== {2'b11, 1'b0, 24'h0}) begin
      bad++;
      $display("FAIL reset_pins_a got=%h want=%h", pins_a(), {2'b11, 1'b0, 24'h0});
    end
    total++;
    if (pins_c() !== 27'h0) begin
      bad++;
      $display("FAIL reset_pins_c got=%h want=0", pins_c());
    end
    total++;
    if (pins_d() !== {2'b11, 1'b0, 24'h0}) begin
      bad++;
      $display("FAIL reset_pins_d got=%h want=%h", pins_d(), {2'b11, 1'b0, 24'h0});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    k = 0;
    total++;
    if ({if_a.new_frame, if_a.vga_h, if_a.vga_v} !== {1'b1, 22'd0}) begin
      bad++;
      $display("FAIL release_first_cycle got nf=%b h=%0d v=%0d want 1 0 0",
               if_a.new_frame, if_a.vga_h, if_a.vga_v);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if ({if_a.new_frame, if_a.vga_h} !== {1'b0, 11'(i)}) begin
        bad++;
        $display("FAIL release_count got nf=%b h=%0d want 0 %0d", if_a.new_frame, if_a.vga_h, i);
      end
    end
  endtask

  task automatic test_counters();
    int last_nf, nf_count;
    do_reset();
    last_nf  = 0;
    nf_count = 0;
    for (int i = 0; i <= 845; i++) begin
      if (i > 0) tick();
      total++;
      if (if_a.vga_h !== 11'(k % SHT) || if_a.vga_v !== 11'((k / SHT) % SVT)) begin
        bad++;
        $display("FAIL counters k=%0d got h=%0d v=%0d want %0d %0d",
                 k, if_a.vga_h, if_a.vga_v, k % SHT, (k / SHT) % SVT);
      end
      if (if_a.new_frame === 1'b1) begin
        nf_count++;
        if (k > 0) begin
          total++;
          if (k - last_nf !== 420) begin
            bad++;
            $display("FAIL new_frame_spacing got=%0d want=420", k - last_nf);
          end
        end
        last_nf = k;
      end
    end
    total++;
    if (nf_count !== 3) begin
      bad++;
      $display("FAIL new_frame_count got=%0d want=3", nf_count);
    end
  endtask

  task automatic test_sync_de();
    int de_n, hs_n, vs_n;
    do_reset();
    de_n = 0;
    hs_n = 0;
    vs_n = 0;
    for (int i = 0; i <= 421; i++) begin
      if (i > 0) tick();
      if (k >= 2) begin
        de_n += int'(if_a.vga_de === 1'b1);
        hs_n += int'(if_a.vga_hsync === 1'b0);
        vs_n += int'(if_a.vga_vsync === 1'b0);
      end
      if (k == 23 || k == 24 || k == 26 || k == 27) begin
        total++;
        if (if_a.vga_hsync !== ((k == 23 || k == 27) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL hsync_edge k=%0d got=%b", k, if_a.vga_hsync);
        end
      end
      if (k == 309 || k == 310 || k == 365 || k == 366) begin
        total++;
        if (if_a.vga_vsync !== ((k == 309 || k == 366) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL vsync_edge k=%0d got=%b", k, if_a.vga_vsync);
        end
      end
    end
    total++;
    if (de_n !== 200) begin
      bad++;
      $display("FAIL de_count got=%0d want=200", de_n);
    end
    total++;
    if (hs_n !== 45) begin
      bad++;
      $display("FAIL hsync_low_count got=%0d want=45", hs_n);
    end
    total++;
    if (vs_n !== 56) begin
      bad++;
      $display("FAIL vsync_low_count got=%0d want=56", vs_n);
    end
  endtask

  task automatic test_colour();
    logic [23:0] want;
    do_reset();
    for (int i = 0; i <= 845; i++) begin
      if (i > 0) tick();
      total++;
      if (pins_a() !== exp_small(k, 1, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL colour_a k=%0d got=%h want=%h", k, pins_a(), exp_small(k, 1, 1'b0, 1'b0));
      end
      if (k == 2 || k == 3 || k == 11 || k == 23 || k == 142) begin
        want = (k == 2) ? 24'hFFFFFF : (k == 11 || k == 142) ? SB : 24'h000000;
        total++;
        if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== want) begin
          bad++;
          $display("FAIL colour_point k=%0d got=%h want=%h",
                   k, {if_a.vga_r, if_a.vga_g, if_a.vga_b}, want);
        end
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int i = 0; i <= 430; i++) begin
      if (i > 0) tick();
      total++;
      if (pins_b() !== exp_small(k, 3, 1'b0, 1'b1)) begin
        bad++;
        $display("FAIL latency_b k=%0d got=%h want=%h", k, pins_b(), exp_small(k, 3, 1'b0, 1'b1));
      end
      if (k >= 8 && k <= 10) begin
        total++;
        if ({if_b.vga_r, if_b.vga_g, if_b.vga_b} !== ((k == 9) ? 24'h000000 : 24'hFFFFFF)) begin
          bad++;
          $display("FAIL latency_point k=%0d got=%h", k, {if_b.vga_r, if_b.vga_g, if_b.vga_b});
        end
      end
    end
  endtask

  task automatic test_polarity();
    int hs_n;
    do_reset();
    hs_n = 0;
    for (int i = 0; i <= 420; i++) begin
      if (i > 0) tick();
      if (k >= 1) hs_n += int'(if_c.vga_hsync === 1'b1);
      total++;
      if (pins_c() !== exp_small(k, 0, 1'b1, 1'b0)) begin
        bad++;
        $display("FAIL polarity_c k=%0d got=%h want=%h", k, pins_c(), exp_small(k, 0, 1'b1, 1'b0));
      end
      if (k == 0 || k == 22 || k == 23 || k == 25 || k == 26) begin
        total++;
        if (if_c.vga_hsync !== ((k == 23 || k == 25) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL pol_hsync_edge k=%0d got=%b", k, if_c.vga_hsync);
        end
      end
      if (k == 308 || k == 309 || k == 364 || k == 365) begin
        total++;
        if (if_c.vga_vsync !== ((k == 309 || k == 364) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL pol_vsync_edge k=%0d got=%b", k, if_c.vga_vsync);
        end
      end
    end
    total++;
    if (hs_n !== 45) begin
      bad++;
      $display("FAIL pol_hsync_count got=%0d want=45", hs_n);
    end
  endtask

  task automatic test_default_timing();
    int hs_n;
    do_reset();
    hs_n = 0;
    for (int i = 0; i <= 2113; i++) begin
      if (i > 0) tick();
      if (k >= 2 && k <= 1057) hs_n += int'(if_d.vga_hsync === 1'b0);
      total++;
      if (if_d.vga_vsync !== 1'b1) begin
        bad++;
        $display("FAIL dflt_vsync k=%0d got=%b want=1", k, if_d.vga_vsync);
      end
      if (k == 0 || k == 1) begin
        total++;
        if (if_d.new_frame !== (k == 0)) begin
          bad++;
          $display("FAIL dflt_new_frame k=%0d got=%b", k, if_d.new_frame);
        end
      end
      if (k == 1055 || k == 1056) begin
        total++;
        if ({if_d.vga_h, if_d.vga_v} !== ((k == 1055) ? {11'd1055, 11'd0} : {11'd0, 11'd1})) begin
          bad++;
          $display("FAIL dflt_wrap k=%0d got h=%0d v=%0d", k, if_d.vga_h, if_d.vga_v);
        end
      end
      if (k == 841 || k == 842 || k == 969 || k == 970) begin
        total++;
        if (if_d.vga_hsync !== ((k == 841 || k == 970) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL dflt_hsync_edge k=%0d got=%b", k, if_d.vga_hsync);
        end
      end
      if (k == 1 || k == 2 || k == 801 || k == 802) begin
        total++;
        if (if_d.vga_de !== ((k == 2 || k == 801) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL dflt_de_edge k=%0d got=%b", k, if_d.vga_de);
        end
      end
      if (k == 2 || k == 3 || k == 1059) begin
        total++;
        if ({if_d.vga_r, if_d.vga_g, if_d.vga_b} !== ((k == 3) ? 24'h000000 : 24'hFFFFFF)) begin
          bad++;
          $display("FAIL dflt_rgb k=%0d got=%h", k, {if_d.vga_r, if_d.vga_g, if_d.vga_b});
        end
      end
    end
    total++;
    if (hs_n !== 128) begin
      bad++;
      $display("FAIL dflt_hsync_low got=%0d want=128", hs_n);
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    total = 0;
    bad   = 0;
    k     = 0;
    test_reset();
    test_counters();
    test_sync_de();
    test_colour();
    test_latency();
    test_polarity();
    test_default_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
